// File: rtl/ifetch.sv
// Instruction fetch front end: PC generation with branch/redirect handling and
// the IC pipeline register that carries the fetch descriptor to decode.
module ifetch #(
   parameter logic [31:0] RESET_PC     = 32'hBFC0_0000,
   parameter int          EXC_ADEL_BIT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic [31:0] new_pc,
   input  logic [2:0]  stall,
   input  logic        br_e,
   input  logic [31:0] br_addr,
   output logic        inst_sram_en,
   output logic [3:0]  inst_sram_wen,
   output logic [31:0] inst_sram_addr,
   output logic [64:0] ic_to_id_bus
);

   logic [31:0] pc_q, pc_d;
   logic        ce_q, ce_d;
   logic        br_pending_q, br_pending_d;
   logic [31:0] br_saved_q, br_saved_d;
   logic [31:0] ic_except_q, ic_except_d;
   logic        ic_ce_q, ic_ce_d;
   logic [31:0] ic_pc_q, ic_pc_d;

   logic        misaligned_s;
   logic [31:0] fetch_exc_s;
   logic [31:0] next_pc_s;

   function automatic logic [31:0] adel_vector(input logic valid, input logic mis);
      logic [31:0] v;
      v = 32'h0000_0000;
      if (valid && mis) begin
         v[EXC_ADEL_BIT] = 1'b1;
      end else begin
         v = 32'h0000_0000;
      end
      return v;
   endfunction

   assign misaligned_s = (pc_q[1:0] != 2'b00);
   assign fetch_exc_s  = adel_vector(ce_q, misaligned_s);

   // Next-PC selection and PC/pending-branch update
   always_comb begin
      pc_d         = pc_q;
      ce_d         = ce_q;
      br_pending_d = br_pending_q;
      br_saved_d   = br_saved_q;
      if (br_e) begin
         next_pc_s = br_addr;
      end else if (br_pending_q) begin
         next_pc_s = br_saved_q;
      end else begin
         next_pc_s = pc_q + 32'd4;
      end
      if (flush) begin
         pc_d         = new_pc;
         ce_d         = 1'b1;
         br_pending_d = 1'b0;
      end else if (!stall[0]) begin
         pc_d         = next_pc_s;
         ce_d         = 1'b1;
         br_pending_d = 1'b0;
      end else if (br_e) begin
         // A branch resolved while the PC is frozen must be remembered until release.
         br_pending_d = 1'b1;
         br_saved_d   = br_addr;
      end else begin
         br_pending_d = br_pending_q;
      end
   end

   // IC stage register: kill, bubble, load or hold
   always_comb begin
      ic_except_d = ic_except_q;
      ic_ce_d     = ic_ce_q;
      ic_pc_d     = ic_pc_q;
      if (flush || (br_e && !stall[1] && !stall[2]) || (stall[1] && !stall[2])) begin
         ic_except_d = 32'h0000_0000;
         ic_ce_d     = 1'b0;
         ic_pc_d     = 32'h0000_0000;
      end else if (!stall[1]) begin
         ic_except_d = fetch_exc_s;
         ic_ce_d     = ce_q;
         ic_pc_d     = pc_q;
      end else begin
         ic_ce_d     = ic_ce_q;
      end
   end

   // State registers
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q         <= RESET_PC - 32'd4;
         ce_q         <= 1'b0;
         br_pending_q <= 1'b0;
         br_saved_q   <= 32'h0000_0000;
         ic_except_q  <= 32'h0000_0000;
         ic_ce_q      <= 1'b0;
         ic_pc_q      <= 32'h0000_0000;
      end else begin
         pc_q         <= pc_d;
         ce_q         <= ce_d;
         br_pending_q <= br_pending_d;
         br_saved_q   <= br_saved_d;
         ic_except_q  <= ic_except_d;
         ic_ce_q      <= ic_ce_d;
         ic_pc_q      <= ic_pc_d;
      end
   end

   assign inst_sram_en   = ce_q & ~misaligned_s;
   assign inst_sram_wen  = 4'b0000;
   assign inst_sram_addr = pc_q;
   assign ic_to_id_bus   = {ic_except_q, ic_ce_q, ic_pc_q};

endmodule

// File: tb/tb_ifetch.sv
// Directed and randomized checks of ifetch against a descriptor-level reference model.
module tb_ifetch;
   localparam logic [31:0] RESET_PC = 32'hBFC0_0000;
   localparam int          EXC_BIT  = 16;

   typedef struct packed {
      logic [31:0] exc;
      logic        ce;
      logic [31:0] pc;
   } desc_t;

   logic        clk = 1'b0;
   logic        rst, flush, br_e;
   logic [31:0] new_pc, br_addr;
   logic [2:0]  stall;
   logic        inst_sram_en;
   logic [3:0]  inst_sram_wen;
   logic [31:0] inst_sram_addr;
   logic [64:0] ic_to_id_bus;

   int errors = 0;
   int checks = 0;

   // Reference model: current fetch, pending redirect (0 or 1 entry), decode-side descriptor
   logic [31:0] m_pc;
   logic        m_ce;
   logic [31:0] m_pend[$];
   desc_t       m_ic;

   ifetch #(.RESET_PC(RESET_PC), .EXC_ADEL_BIT(EXC_BIT)) dut (
      .clk(clk), .rst(rst), .flush(flush), .new_pc(new_pc), .stall(stall),
      .br_e(br_e), .br_addr(br_addr), .inst_sram_en(inst_sram_en),
      .inst_sram_wen(inst_sram_wen), .inst_sram_addr(inst_sram_addr),
      .ic_to_id_bus(ic_to_id_bus)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] exc_of(input logic [31:0] pc, input logic ce);
      return (ce && pc[1:0] != 2'b00) ? (32'd1 << EXC_BIT) : 32'd0;
   endfunction

   task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic r, input logic f, input logic [31:0] np,
                       input logic [2:0] st, input logic b, input logic [31:0] ba);
      desc_t fetched;
      rst = r; flush = f; new_pc = np; stall = st; br_e = b; br_addr = ba;
      @(posedge clk);
      if (r) begin
         m_pc = RESET_PC - 32'd4;
         m_ce = 1'b0;
         m_pend.delete();
         m_ic = '0;
      end else begin
         fetched = {exc_of(m_pc, m_ce), m_ce, m_pc};
         if (f || (b && !st[1] && !st[2]) || (st[1] && !st[2])) m_ic = '0;
         else if (!st[1]) m_ic = fetched;
         if (f) begin
            m_pc = np; m_ce = 1'b1; m_pend.delete();
         end else if (!st[0]) begin
            if (b) m_pc = ba;
            else if (m_pend.size() > 0) m_pc = m_pend[0];
            else m_pc = m_pc + 32'd4;
            m_ce = 1'b1;
            m_pend.delete();
         end else if (b) begin
            m_pend.delete();
            m_pend.push_back(ba);
         end
      end
      #1;
      chk("model_en", 65'(inst_sram_en), 65'(m_ce && m_pc[1:0] == 2'b00));
      chk("model_addr", 65'(inst_sram_addr), 65'(m_pc));
      chk("wen", 65'(inst_sram_wen), 65'd0);
      chk("model_bus", ic_to_id_bus, m_ic);
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 32'd0, 3'b000, 1'b0, 32'd0);
   endtask

   initial begin
      // Reset
      step(1'b1, 1'b0, 32'd0, 3'b000, 1'b0, 32'd0);
      step(1'b1, 1'b0, 32'd0, 3'b000, 1'b1, 32'h1234_0000);
      chk("rst_addr", 65'(inst_sram_addr), 65'h0_BFBF_FFFC);
      chk("rst_en", 65'(inst_sram_en), 65'd0);
      chk("rst_bus", ic_to_id_bus, 65'd0);

      // Sequential fetch after reset
      for (int i = 0; i < 3; i++) begin
         idle();
         chk("seq_addr", 65'(inst_sram_addr), 65'(32'hBFC0_0000 + 32'(4 * i)));
         chk("seq_en", 65'(inst_sram_en), 65'd1);
         if (i > 0) begin
            chk("seq_ic_pc", 65'(ic_to_id_bus[31:0]), 65'(32'hBFC0_0000 + 32'(4 * (i - 1))));
            chk("seq_ic_ce", 65'(ic_to_id_bus[32]), 65'd1);
         end
      end

      // Taken branch at 0xBFC00008
      step(1'b0, 1'b0, 32'd0, 3'b000, 1'b1, 32'hBFC0_0100);
      chk("br_addr", 65'(inst_sram_addr), 65'h0_BFC0_0100);
      chk("br_kill", ic_to_id_bus, 65'd0);
      idle();
      chk("br_next", 65'(inst_sram_addr), 65'h0_BFC0_0104);

      // Branch during full stall is remembered
      step(1'b0, 1'b0, 32'd0, 3'b111, 1'b0, 32'd0);
      step(1'b0, 1'b0, 32'd0, 3'b111, 1'b1, 32'h8000_0040);
      step(1'b0, 1'b0, 32'd0, 3'b111, 1'b0, 32'd0);
      chk("stall_hold", 65'(inst_sram_addr), 65'h0_BFC0_0104);
      idle();
      chk("pend_addr", 65'(inst_sram_addr), 65'h0_8000_0040);
      idle();
      chk("pend_clr", 65'(inst_sram_addr), 65'h0_8000_0044);

      // Flush beats branch
      step(1'b0, 1'b1, 32'hBFC0_0380, 3'b000, 1'b1, 32'h0000_1000);
      chk("flush_addr", 65'(inst_sram_addr), 65'h0_BFC0_0380);
      chk("flush_bus", ic_to_id_bus, 65'd0);
      idle();
      chk("flush_nojump", 65'(inst_sram_addr), 65'h0_BFC0_0384);

      // Misaligned redirect raises AdEL
      step(1'b0, 1'b1, 32'hBFC0_0382, 3'b000, 1'b0, 32'd0);
      chk("adel_en", 65'(inst_sram_en), 65'd0);
      idle();
      chk("adel_bus", ic_to_id_bus, {32'h0001_0000, 1'b1, 32'hBFC0_0382});

      // IC bubble while PC frozen
      step(1'b0, 1'b0, 32'd0, 3'b011, 1'b0, 32'd0);
      chk("bubble_bus", ic_to_id_bus, 65'd0);
      chk("bubble_pc", 65'(inst_sram_addr), 65'h0_BFC0_0386);

      // Reset discards a pending branch
      step(1'b0, 1'b0, 32'd0, 3'b001, 1'b1, 32'h0000_ABC0);
      step(1'b1, 1'b0, 32'd0, 3'b001, 1'b0, 32'd0);
      idle();
      chk("rst_pend", 65'(inst_sram_addr), 65'h0_BFC0_0000);

      // Randomized traffic
      for (int n = 0; n < 600; n++) begin
         logic r, f, b;
         logic [31:0] np, ba;
         logic [2:0] st;
         r  = ($urandom_range(0, 99) == 0);
         f  = ($urandom_range(0, 19) == 0);
         b  = ($urandom_range(0, 3) == 0);
         st = {($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0)};
         np = $urandom();
         if ($urandom_range(0, 7) != 0) np[1:0] = 2'b00;
         ba = $urandom() & 32'hFFFF_FFFC;
         if ($urandom_range(0, 49) == 0) ba = 32'hFFFF_FFF8;
         step(r, f, np, st, b, ba);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/ifetch.md
IFETCH -- requirements
Module: ifetch

Interface
REQ-001 Parameter RESET_PC, default 32'hBFC0_0000, first fetch address after reset.
REQ-002 Parameter EXC_ADEL_BIT, default 16, excepttype bit set on misaligned fetch.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 flush  input  1  exception/eret redirect; kills in-flight fetch state.
REQ-006 new_pc  input  32  redirect target, valid when flush=1.
REQ-007 stall  input  `StallBus  stall[0]=1 freezes PC; stall[1]=1 freezes IC stage; stall[2]=1 freezes ID.
REQ-008 br_e  input  1  branch taken, one-cycle pulse from execute.
REQ-009 br_addr  input  32  branch target, valid when br_e=1.
REQ-010 inst_sram_en  output  1  fetch request to synchronous instruction SRAM.
REQ-011 inst_sram_wen  output  4  always 4'b0000.
REQ-012 inst_sram_addr  output  32  fetch address; equals pc_reg.
REQ-013 ic_to_id_bus  output  `IC_TO_ID_WD (65)  {excepttype[31:0], ic_ce, ic_pc[31:0]}, consumed by ID with ic_inst one cycle after request.

Function
REQ-014 PC register pc_reg plus valid bit ce_reg; ce_reg=0 means no fetch issued.
REQ-015 Next-PC priority, highest first: flush -> new_pc; br_e -> br_addr; br_pending -> br_saved; else pc_reg+4 (32-bit, wraps 32'hFFFF_FFFC -> 32'h0000_0000).
REQ-016 flush loads pc_reg regardless of stall; ce_reg set to 1; br_pending cleared.
REQ-017 If stall[0]=0, pc_reg loads next-PC each cycle and ce_reg=1.
REQ-018 If stall[0]=1, pc_reg and ce_reg hold; br_e during stall sets br_pending=1, br_saved=br_addr.
REQ-019 br_pending consumed (cleared) on first cycle with stall[0]=0; later br_e in same stall overwrites br_saved.
REQ-020 br_e with stall[0]=0 takes effect next cycle; br_pending not set.
REQ-021 inst_sram_en = ce_reg & ~misaligned, misaligned = (pc_reg[1:0] != 2'b00).
REQ-022 Fetch exception vector: bit EXC_ADEL_BIT set when ce_reg & misaligned; all other bits 0.
REQ-023 IC stage register {ic_except, ic_ce, ic_pc} loads {exception vector, ce_reg, pc_reg} when stall[1]=0.
REQ-024 IC stage register loads bubble (all zero) when: flush; or br_e with stall[1]=0 and stall[2]=0; or stall[1]=1 and stall[2]=0.
REQ-025 IC stage register holds when stall[1]=1 and stall[2]=1.
REQ-026 Priority within IC stage: rst > flush > br_e kill > stall bubble > load > hold.
REQ-027 ic_to_id_bus driven directly from IC stage register; no combinational path from br_e or stall to the bus.
REQ-028 No fetch is issued twice for the same pc_reg value except while stall[0]=1 holds it; SRAM address stays stable during stall.

Reset
REQ-029 On rst: pc_reg=RESET_PC-4 (32'hBFBF_FFFC), ce_reg=0, br_pending=0, br_saved=0, IC stage register all zero.
REQ-030 During rst: inst_sram_en=0, inst_sram_addr=32'hBFBF_FFFC, ic_to_id_bus=0.
REQ-031 First cycle after rst deasserts with stall=0: inst_sram_addr=32'hBFC0_0000, inst_sram_en=1.
REQ-032 rst mid-stall or with br_pending=1 discards all pending state; no redirect survives reset.

Verification
REQ-033 Release rst, stall=0 for 4 cycles -> inst_sram_addr 0xBFC00000, 0xBFC00004, 0xBFC00008, 0xBFC0000C; ic_pc lags by one cycle, ic_ce=1.
REQ-034 At pc=0xBFC00008 pulse br_e, br_addr=0xBFC00100, stall=0 -> next addr 0xBFC00100; ic_to_id_bus zero that next cycle.
REQ-035 stall[0]=stall[1]=stall[2]=1 for 3 cycles, br_e pulse in cycle 2 with br_addr=0x80000040 -> addr held; after release next addr=0x80000040, br_pending=0.
REQ-036 br_e and flush same cycle, br_addr=0x1000, new_pc=0xBFC00380 -> next addr 0xBFC00380; IC stage zero; no later jump to 0x1000.
REQ-037 flush with new_pc=0xBFC00382 -> inst_sram_en=0, next cycle ic_pc=0xBFC00382, ic_ce=1, excepttype=32'h0001_0000.
REQ-038 stall[1]=1, stall[2]=0 for one cycle -> ic_to_id_bus=0 that cycle; pc_reg unchanged if stall[0]=1.
